fetch_sequencer: RTL and testbench

//  Program-counter and fetch/execute sequencer for the 3-stage RV32 core (fetch, execute, writeback).

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and fetch/execute sequencer for the 3-stage RV32 core.
// Owns the fetch PC, tags the EX instruction valid, and handles stall, redirect, halt and boot delay.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_DEPTH  = 4096,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_res,
  input  logic                          i_stall_req,
  input  logic                          i_branch_taken,
  input  logic [31:0]                   i_branch_target,
  input  logic                          i_halt_req,
  input  logic                          i_resume,
  output logic [$clog2(IMEM_DEPTH)-1:0] o_imem_addr,
  output logic                          o_ir_we,
  output logic [31:0]                   o_pc_F,
  output logic [31:0]                   o_pc_EX,
  output logic                          o_valid_EX,
  output logic [31:0]                   o_retire_cnt,
  output logic                          o_halted,
  output logic                          o_err
);

  localparam int          AW       = $clog2(IMEM_DEPTH);
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) << 2;
  localparam logic [3:0]  BOOT_END = 4'(BOOT_CYCLES);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [3:0]  r_bootCnt;
  logic [31:0] r_pcF;
  logic [31:0] r_pcEx;
  logic        r_validEx;
  logic [31:0] r_retireCnt;
  logic        r_err;

  logic        w_fault;
  logic        w_targetMisaligned;
  logic [31:0] w_retireNext;

  // A fetch PC that is misaligned or beyond the end of instruction memory must never be fetched.
  assign w_fault            = (r_pcF[1:0] != 2'b00) || ({1'b0, r_pcF} >= PC_LIMIT);
  assign w_targetMisaligned = (i_branch_target[1:0] != 2'b00);
  assign w_retireNext       = r_retireCnt + 32'(r_validEx);

  assign o_imem_addr  = r_pcF[AW+1:2];
  assign o_ir_we      = (r_state == S_RUN) && !i_stall_req && !w_fault;
  assign o_halted     = (r_state == S_HALT);
  assign o_pc_F       = r_pcF;
  assign o_pc_EX      = r_pcEx;
  assign o_valid_EX   = r_validEx;
  assign o_retire_cnt = r_retireCnt;
  assign o_err        = r_err;

  always_ff @(posedge i_clk) begin
    if (!i_res) begin
      r_state     <= S_BOOT;
      r_bootCnt   <= 4'd0;
      r_pcF       <= RESET_PC;
      r_pcEx      <= 32'd0;
      r_validEx   <= 1'b0;
      r_retireCnt <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (r_bootCnt == BOOT_END) begin
            r_state <= S_RUN;
          end else begin
            r_bootCnt <= r_bootCnt + 4'd1;
          end
        end

        S_RUN: begin
          // A stalled EX instruction has not finished, so its branch/halt requests are not yet meaningful.
          if (!i_stall_req) begin
            if (w_fault) begin
              r_err       <= 1'b1;
              r_state     <= S_HALT;
              r_validEx   <= 1'b0;
              r_retireCnt <= w_retireNext;
            end else if (r_validEx && i_branch_taken) begin
              r_retireCnt <= r_retireCnt + 32'd1;
              r_validEx   <= 1'b0;
              if (w_targetMisaligned) begin
                r_err   <= 1'b1;
                r_state <= S_HALT;
              end else begin
                r_pcF <= i_branch_target;
                if (i_halt_req) begin
                  r_state <= S_HALT;
                end
              end
            end else if (r_validEx && i_halt_req) begin
              r_retireCnt <= r_retireCnt + 32'd1;
              r_validEx   <= 1'b0;
              r_state     <= S_HALT;
            end else begin
              r_pcEx      <= r_pcF;
              r_validEx   <= 1'b1;
              r_pcF       <= r_pcF + 32'd4;
              r_retireCnt <= w_retireNext;
            end
          end
        end

        S_HALT: begin
          r_validEx <= 1'b0;
          if (i_resume) begin
            r_state <= S_RUN;
          end
        end

        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer: boot, redirect, stall, halt/resume, faults, mid-op reset.
module tb_fetch_sequencer;

  localparam int IMEM_DEPTH = 32;
  localparam int AW         = $clog2(IMEM_DEPTH);

  logic          clk;
  logic          res;
  logic          stallReq;
  logic          branchTaken;
  logic [31:0]   branchTarget;
  logic          haltReq;
  logic          resume;
  logic [AW-1:0] imemAddr;
  logic          irWe;
  logic [31:0]   pcF;
  logic [31:0]   pcEx;
  logic          validEx;
  logic [31:0]   retireCnt;
  logic          halted;
  logic          err;

  int testsRun  = 0;
  int failCount = 0;

  fetch_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (IMEM_DEPTH),
    .BOOT_CYCLES(2)
  ) dut (
    .i_clk          (clk),
    .i_res          (res),
    .i_stall_req    (stallReq),
    .i_branch_taken (branchTaken),
    .i_branch_target(branchTarget),
    .i_halt_req     (haltReq),
    .i_resume       (resume),
    .o_imem_addr    (imemAddr),
    .o_ir_we        (irWe),
    .o_pc_F         (pcF),
    .o_pc_EX        (pcEx),
    .o_valid_EX     (validEx),
    .o_retire_cnt   (retireCnt),
    .o_halted       (halted),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic stall, input logic branch, input logic [31:0] target,
                               input logic halt, input logic res_resume);
    stallReq     = stall;
    branchTaken  = branch;
    branchTarget = target;
    haltReq      = halt;
    resume       = res_resume;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // pc_EX is only meaningful while valid_EX is expected high.
  task automatic checkAll(input string tag, input logic [31:0] expPcF, input logic [31:0] expPcEx,
                          input logic expValid, input logic [31:0] expRetire, input logic expIrWe,
                          input logic expHalted, input logic expErr);
    checkOutput({tag, ".pc_F"}, pcF, expPcF);
    if (expValid) checkOutput({tag, ".pc_EX"}, pcEx, expPcEx);
    checkOutput({tag, ".valid_EX"}, {31'd0, validEx}, {31'd0, expValid});
    checkOutput({tag, ".retire_cnt"}, retireCnt, expRetire);
    checkOutput({tag, ".ir_we"}, {31'd0, irWe}, {31'd0, expIrWe});
    checkOutput({tag, ".halted"}, {31'd0, halted}, {31'd0, expHalted});
    checkOutput({tag, ".err"}, {31'd0, err}, {31'd0, expErr});
  endtask

  initial begin
    res = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset and boot delay
    waitCycles(2);
    checkAll("reset", 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.pc_EX", pcEx, 32'h0);
    checkOutput("reset.imem_addr", 32'(imemAddr), 32'h0);
    res = 1'b1;
    waitCycles(1);
    checkAll("boot1", 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("boot2", 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("run0", 32'h0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("fetch4", 32'h4, 32'h0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("fetch8", 32'h8, 32'h4, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("fetchC", 32'hC, 32'h8, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("fetchC.imem_addr", 32'(imemAddr), 32'h3);

    // Branch redirect with one bubble
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkAll("brBubble", 32'h40, 32'h0, 1'b0, 32'd3, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("brTarget", 32'h44, 32'h40, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("brTarget.imem_addr", 32'(imemAddr), 32'h11);

    // Stall holds everything and masks a branch
    applyStimulus(1'b1, 1'b1, 32'h20, 1'b0, 1'b0);
    #1;
    checkAll("stallIn", 32'h44, 32'h40, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      waitCycles(1);
      checkAll("stallHold", 32'h44, 32'h40, 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("stallRel", 32'h48, 32'h44, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0);

    // Halt and resume without skipping an instruction
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkAll("haltEnter", 32'h48, 32'h0, 1'b0, 32'd5, 1'b0, 1'b1, 1'b0);
    waitCycles(2);
    checkAll("haltHold", 32'h48, 32'h0, 1'b0, 32'd5, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkAll("resumeRun", 32'h48, 32'h0, 1'b0, 32'd5, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("resumeEx", 32'h4C, 32'h48, 1'b1, 32'd5, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect: sticky err, PC holds
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkAll("misalign", 32'h4C, 32'h0, 1'b0, 32'd6, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkAll("misResume", 32'h4C, 32'h0, 1'b0, 32'd6, 1'b1, 1'b0, 1'b1);
    waitCycles(1);
    checkAll("errSticky", 32'h50, 32'h4C, 1'b1, 32'd6, 1'b1, 1'b0, 1'b1);

    // Reset during a stall
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    res = 1'b0;
    waitCycles(1);
    checkAll("rstStall", 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstStall.pc_EX", pcEx, 32'h0);
    res = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    waitCycles(3);
    checkAll("reboot", 32'h0, 32'h0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("reboot4", 32'h4, 32'h0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0);

    // Run off the end of instruction memory (limit 0x80)
    applyStimulus(1'b0, 1'b1, 32'h78, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkAll("brNear", 32'h78, 32'h0, 1'b0, 32'd1, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("last78", 32'h7C, 32'h78, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("atLimit", 32'h80, 32'h7C, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
    waitCycles(1);
    checkAll("depthFault", 32'h80, 32'h0, 1'b0, 32'd3, 1'b0, 1'b1, 1'b1);

    // Reset while halted
    res = 1'b0;
    waitCycles(1);
    checkAll("rstHalt", 32'h0, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("rstHalt.pc_EX", pcEx, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
